// File: rtl/bip_run_controller.sv
// rtl/bip_run_controller.sv - host-link sequencer that loads, runs, steps and dumps the BIP CPU
module bip_run_controller #(
   parameter int                       PC_CANT_BITS  = 11,
   parameter int                       OPCODE_LENGTH = 5,
   parameter int                       INSTR_WIDTH   = 16,
   parameter int                       DATA_WIDTH    = 16,
   parameter logic [OPCODE_LENGTH-1:0] HALT_OPCODE   = '0
) (
   input  logic                     i_clock,
   input  logic                     i_soft_reset,
   input  logic [7:0]               i_rx_data,
   input  logic                     i_rx_valid,
   output logic [7:0]               o_tx_data,
   output logic                     o_tx_valid,
   input  logic                     i_tx_ready,
   output logic                     o_prog_we,
   output logic [PC_CANT_BITS-1:0]  o_prog_addr,
   output logic [INSTR_WIDTH-1:0]   o_prog_data,
   output logic                     o_cpu_enable,
   output logic                     o_cpu_reset,
   input  logic [OPCODE_LENGTH-1:0] i_opcode,
   input  logic [PC_CANT_BITS-1:0]  i_pc,
   input  logic [DATA_WIDTH-1:0]    i_acc,
   output logic                     o_busy
);

   localparam logic [7:0] CMD_LOAD  = 8'h4C;
   localparam logic [7:0] CMD_RUN   = 8'h52;
   localparam logic [7:0] CMD_STEP  = 8'h53;
   localparam logic [2:0] LAST_BYTE = 3'd5;

   typedef enum logic [2:0] {
      IDLE, LD_COUNT, LD_HI, LD_LO, CPU_RST, RUN, STEP, DUMP
   } state_t;

   state_t                  state, state_next;
   logic [7:0]              count_n;
   logic [PC_CANT_BITS-1:0] addr_cnt;
   logic [7:0]              word_hi;
   logic                    prog_we_q;
   logic [PC_CANT_BITS-1:0] prog_addr_q;
   logic [INSTR_WIDTH-1:0]  prog_data_q;
   logic [15:0]             cyc_cnt;
   logic [15:0]             snap_pc, snap_acc, snap_cyc;
   logic [2:0]              byte_idx;
   logic                    tx_valid_q;
   logic [7:0]              tx_byte;
   logic                    cpu_enable;
   logic                    is_halt;
   logic                    last_word;

   assign is_halt   = (i_opcode == HALT_OPCODE);
   assign last_word = ((addr_cnt + PC_CANT_BITS'(1)) == PC_CANT_BITS'(count_n));

   always_ff @(posedge i_clock) begin
      if (i_soft_reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Enable is combinational so the HALT instruction itself is never executed.
   always_comb begin
      state_next = state;
      cpu_enable = 1'b0;
      case (state)
         IDLE: begin
            if (i_rx_valid) begin
               case (i_rx_data)
                  CMD_LOAD: state_next = LD_COUNT;
                  CMD_RUN:  state_next = RUN;
                  CMD_STEP: state_next = STEP;
                  default:  state_next = IDLE;
               endcase
            end
         end
         LD_COUNT: begin
            if (i_rx_valid) begin
               state_next = (i_rx_data == 8'h00) ? IDLE : LD_HI;
            end
         end
         LD_HI: begin
            if (i_rx_valid) begin
               state_next = LD_LO;
            end
         end
         LD_LO: begin
            if (i_rx_valid) begin
               state_next = last_word ? CPU_RST : LD_HI;
            end
         end
         CPU_RST: state_next = IDLE;
         RUN: begin
            if (is_halt) begin
               state_next = DUMP;
            end else begin
               cpu_enable = 1'b1;
            end
         end
         STEP: begin
            cpu_enable = !is_halt;
            state_next = DUMP;
         end
         DUMP: begin
            if (tx_valid_q && i_tx_ready && (byte_idx == LAST_BYTE)) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge i_clock) begin
      if (i_soft_reset) begin
         count_n     <= '0;
         addr_cnt    <= '0;
         word_hi     <= '0;
         prog_we_q   <= 1'b0;
         prog_addr_q <= '0;
         prog_data_q <= '0;
         cyc_cnt     <= '0;
         snap_pc     <= '0;
         snap_acc    <= '0;
         snap_cyc    <= '0;
         byte_idx    <= '0;
         tx_valid_q  <= 1'b0;
      end else begin
         prog_we_q <= 1'b0;
         case (state)
            LD_COUNT: begin
               if (i_rx_valid && (i_rx_data != 8'h00)) begin
                  count_n  <= i_rx_data;
                  addr_cnt <= '0;
               end
            end
            LD_HI: begin
               if (i_rx_valid) begin
                  word_hi <= i_rx_data;
               end
            end
            LD_LO: begin
               if (i_rx_valid) begin
                  prog_we_q   <= 1'b1;
                  prog_addr_q <= addr_cnt;
                  prog_data_q <= INSTR_WIDTH'({word_hi, i_rx_data});
                  addr_cnt    <= addr_cnt + PC_CANT_BITS'(1);
               end
            end
            CPU_RST: cyc_cnt <= '0;
            // Snapshot one cycle after entry so a STEP's own instruction is reflected.
            DUMP: begin
               if (!tx_valid_q) begin
                  snap_pc    <= 16'(i_pc);
                  snap_acc   <= 16'(i_acc);
                  snap_cyc   <= cyc_cnt;
                  byte_idx   <= '0;
                  tx_valid_q <= 1'b1;
               end else if (i_tx_ready) begin
                  if (byte_idx == LAST_BYTE) begin
                     tx_valid_q <= 1'b0;
                     byte_idx   <= '0;
                  end else begin
                     byte_idx <= byte_idx + 3'd1;
                  end
               end
            end
            default: ;
         endcase
         if (cpu_enable && (cyc_cnt != 16'hFFFF)) begin
            cyc_cnt <= cyc_cnt + 16'd1;
         end
      end
   end

   always_comb begin
      tx_byte = 8'h00;
      case (byte_idx)
         3'd0:    tx_byte = snap_pc[15:8];
         3'd1:    tx_byte = snap_pc[7:0];
         3'd2:    tx_byte = snap_acc[15:8];
         3'd3:    tx_byte = snap_acc[7:0];
         3'd4:    tx_byte = snap_cyc[15:8];
         3'd5:    tx_byte = snap_cyc[7:0];
         default: tx_byte = 8'h00;
      endcase
   end

   assign o_tx_data    = tx_valid_q ? tx_byte : 8'h00;
   assign o_tx_valid   = tx_valid_q;
   assign o_prog_we    = prog_we_q;
   assign o_prog_addr  = prog_addr_q;
   assign o_prog_data  = prog_data_q;
   assign o_cpu_enable = cpu_enable;
   assign o_cpu_reset  = (state == CPU_RST);
   assign o_busy       = (state != IDLE);

endmodule

// File: tb/tb_bip_run_controller.sv
// tb/tb_bip_run_controller.sv - randomized self-checking bench for bip_run_controller
module tb_bip_run_controller;

   localparam logic [4:0] OP_STO = 5'd1, OP_LD = 5'd2, OP_LDI = 5'd3, OP_ADDI = 5'd5, OP_JMP = 5'd8;

   logic        i_clock = 1'b0;
   logic        i_soft_reset = 1'b1;
   logic [7:0]  i_rx_data = 8'h00;
   logic        i_rx_valid = 1'b0;
   logic [7:0]  o_tx_data;
   logic        o_tx_valid;
   logic        i_tx_ready = 1'b0;
   logic        o_prog_we;
   logic [10:0] o_prog_addr;
   logic [15:0] o_prog_data;
   logic        o_cpu_enable;
   logic        o_cpu_reset;
   logic [4:0]  i_opcode;
   logic [10:0] i_pc;
   logic [15:0] i_acc;
   logic        o_busy;

   int total = 0;
   int bad = 0;

   always #5 i_clock = ~i_clock;

   bip_run_controller dut (
      .i_clock(i_clock), .i_soft_reset(i_soft_reset),
      .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid),
      .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid), .i_tx_ready(i_tx_ready),
      .o_prog_we(o_prog_we), .o_prog_addr(o_prog_addr), .o_prog_data(o_prog_data),
      .o_cpu_enable(o_cpu_enable), .o_cpu_reset(o_cpu_reset),
      .i_opcode(i_opcode), .i_pc(i_pc), .i_acc(i_acc), .o_busy(o_busy)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Cycle-level CPU + program memory, fed only by the DUT's strobes
   logic [15:0] imem [0:2047];
   logic [15:0] dmem [0:2047];
   logic [10:0] cpu_pc = 11'd0;
   logic [15:0] cpu_acc = 16'd0;
   bit          force_halt = 1'b0;

   assign i_opcode = force_halt ? 5'd0 : imem[cpu_pc][15:11];
   assign i_pc     = cpu_pc;
   assign i_acc    = cpu_acc;

   always @(posedge i_clock) begin
      if (o_prog_we) imem[o_prog_addr] <= o_prog_data;
      if (o_cpu_reset) begin
         cpu_pc  <= 11'd0;
         cpu_acc <= 16'd0;
      end else if (o_cpu_enable) begin
         cpu_pc <= cpu_pc + 11'd1;
         case (imem[cpu_pc][15:11])
            OP_STO:  dmem[imem[cpu_pc][10:0]] <= cpu_acc;
            OP_LD:   cpu_acc <= dmem[imem[cpu_pc][10:0]];
            OP_LDI:  cpu_acc <= {5'd0, imem[cpu_pc][10:0]};
            OP_ADDI: cpu_acc <= cpu_acc + {5'd0, imem[cpu_pc][10:0]};
            OP_JMP:  cpu_pc <= imem[cpu_pc][10:0];
            default: ;
         endcase
      end
   end

   // Instruction-level reference: program image, data memory and architectural counters
   logic [15:0] rmem [0:2047];
   logic [15:0] rdmem [0:2047];
   logic [10:0] r_pc = 11'd0;
   logic [15:0] r_acc = 16'd0;
   int          r_cyc = 0;
   logic [15:0] prog_q[$];

   initial begin
      for (int i = 0; i < 2048; i++) begin
         imem[i] = 16'h0; dmem[i] = 16'h0; rmem[i] = 16'h0; rdmem[i] = 16'h0;
      end
   end

   function automatic void ref_exec();
      logic [15:0] w;
      w = rmem[r_pc];
      r_pc = r_pc + 11'd1;
      case (w[15:11])
         OP_STO:  rdmem[w[10:0]] = r_acc;
         OP_LD:   r_acc = rdmem[w[10:0]];
         OP_LDI:  r_acc = {5'd0, w[10:0]};
         OP_ADDI: r_acc = r_acc + {5'd0, w[10:0]};
         OP_JMP:  r_pc = w[10:0];
         default: ;
      endcase
      if (r_cyc < 65535) r_cyc++;
   endfunction

   // Monitors and tx-ready driver, all on the falling edge
   logic [10:0] wr_addr_q[$];
   logic [15:0] wr_data_q[$];
   logic [7:0]  tx_q[$];
   int          n_rst = 0;
   int          n_en = 0;
   int          ready_mode = 0;
   int          stall = 0;
   bit          prev_stall = 1'b0;
   logic [7:0]  prev_data = 8'h00;

   always @(negedge i_clock) begin
      if (o_prog_we) begin
         wr_addr_q.push_back(o_prog_addr);
         wr_data_q.push_back(o_prog_data);
      end
      if (o_cpu_reset) n_rst++;
      if (o_cpu_enable) begin
         n_en++;
         check("en_we_excl", {31'd0, o_prog_we}, 32'd0);
      end
      if (prev_stall) begin
         check("tx_hold_valid", {31'd0, o_tx_valid}, 32'd1);
         check("tx_hold_data", {24'd0, o_tx_data}, {24'd0, prev_data});
      end
      case (ready_mode)
         0: i_tx_ready = 1'b1;
         1: i_tx_ready = 1'($urandom_range(0, 1));
         default: begin
            if (o_tx_valid && stall < 5) begin
               i_tx_ready = 1'b0;
               stall++;
            end else begin
               i_tx_ready = o_tx_valid;
               stall = 0;
            end
         end
      endcase
      if (o_tx_valid && i_tx_ready && !i_soft_reset) tx_q.push_back(o_tx_data);
      prev_stall = o_tx_valid && !i_tx_ready && !i_soft_reset;
      prev_data  = o_tx_data;
   end

   task automatic tick();
      @(posedge i_clock);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      repeat ($urandom_range(0, 2)) tick();
      i_rx_data  = b;
      i_rx_valid = 1'b1;
      tick();
      i_rx_valid = 1'b0;
   endtask

   task automatic wait_idle(input int budget, input string tag);
      int n = 0;
      while (o_busy && n < budget) begin
         tick();
         n++;
      end
      check({tag, "_idle"}, {31'd0, o_busy}, 32'd0);
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_busy"}, {31'd0, o_busy}, 32'd0);
      check({tag, "_txv"}, {31'd0, o_tx_valid}, 32'd0);
      check({tag, "_txd"}, {24'd0, o_tx_data}, 32'd0);
      check({tag, "_we"}, {31'd0, o_prog_we}, 32'd0);
      check({tag, "_addr"}, {21'd0, o_prog_addr}, 32'd0);
      check({tag, "_data"}, {16'd0, o_prog_data}, 32'd0);
      check({tag, "_en"}, {31'd0, o_cpu_enable}, 32'd0);
      check({tag, "_crst"}, {31'd0, o_cpu_reset}, 32'd0);
   endtask

   task automatic load_prog();
      int w0 = wr_addr_q.size();
      int r0 = n_rst;
      send(8'h4C);
      send(8'(prog_q.size()));
      foreach (prog_q[i]) begin
         send(prog_q[i][15:8]);
         send(prog_q[i][7:0]);
         rmem[i] = prog_q[i];
      end
      wait_idle(20, "load");
      check("load_nwr", wr_addr_q.size() - w0, prog_q.size());
      for (int i = 0; i < prog_q.size(); i++) begin
         if (w0 + i < wr_addr_q.size()) begin
            check("load_addr", {21'd0, wr_addr_q[w0+i]}, i);
            check("load_data", {16'd0, wr_data_q[w0+i]}, {16'd0, prog_q[i]});
         end
      end
      check("load_cpu_rst", n_rst - r0, 1);
      r_pc = 11'd0;
      r_acc = 16'd0;
      r_cyc = 0;
   endtask

   // 'R' or 'S'; hold>0 releases an endless program by forcing HALT after hold cycles
   task automatic run_cmd(input logic [7:0] c, input int hold, input string tag);
      int w0 = wr_addr_q.size();
      int r0 = n_rst;
      int e0 = n_en;
      int nexec = 0;
      logic [47:0] exp;
      tx_q.delete();
      if (c == 8'h53) begin
         if (rmem[r_pc][15:11] != 5'd0) begin
            ref_exec();
            nexec = 1;
         end
      end else begin
         while (rmem[r_pc][15:11] != 5'd0 && (hold == 0 || nexec < hold)) begin
            ref_exec();
            nexec++;
         end
      end
      exp = {5'd0, r_pc, r_acc, 16'(r_cyc)};
      send(c);
      if (hold > 0) begin
         for (int k = 0; k < hold; k++) begin
            i_rx_data  = (k % 2 == 0) ? 8'h4C : 8'h53;
            i_rx_valid = (k % 4096 == 7);
            tick();
         end
         i_rx_valid = 1'b0;
         force_halt = 1'b1;
      end
      wait_idle(200, tag);
      force_halt = 1'b0;
      check({tag, "_nbytes"}, tx_q.size(), 6);
      for (int i = 0; i < 6; i++) begin
         check({tag, "_byte"}, (i < tx_q.size()) ? {24'd0, tx_q[i]} : 32'h100, {24'd0, exp[47-8*i -: 8]});
      end
      check({tag, "_en_cycles"}, n_en - e0, nexec);
      check({tag, "_no_wr"}, wr_addr_q.size() - w0, 0);
      check({tag, "_no_crst"}, n_rst - r0, 0);
   endtask

   initial begin
      #5000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int w0;
      int r0;
      logic [7:0] b;
      repeat (3) tick();
      @(negedge i_clock);
      check_zero("reset");
      i_soft_reset = 1'b0;
      tick();

      // load and run
      prog_q = '{16'h0805, 16'h1003, 16'h0000};
      load_prog();
      run_cmd(8'h52, 0, "run");

      // three single steps, the last on HALT
      load_prog();
      run_cmd(8'h53, 0, "step1");
      run_cmd(8'h53, 0, "step2");
      run_cmd(8'h53, 0, "step3");

      // tx backpressure
      ready_mode = 2;
      prog_q = '{16'h1805, 16'h2803, 16'h0000};
      load_prog();
      run_cmd(8'h52, 0, "bp_run");
      ready_mode = 0;

      // N=0 and unknown command
      w0 = wr_addr_q.size();
      r0 = n_rst;
      send(8'h4C);
      send(8'h00);
      check("n0_busy", {31'd0, o_busy}, 32'd0);
      send(8'h41);
      check("unk_busy", {31'd0, o_busy}, 32'd0);
      repeat (4) tick();
      check("edge_no_wr", wr_addr_q.size() - w0, 0);
      check("edge_no_crst", n_rst - r0, 0);

      // reset in LD_LO, coincident with the low byte
      w0 = wr_addr_q.size();
      send(8'h4C);
      send(8'h02);
      send(8'h18);
      i_rx_data = 8'h07;
      i_rx_valid = 1'b1;
      i_soft_reset = 1'b1;
      @(posedge i_clock);
      @(negedge i_clock);
      check_zero("rst_ldlo");
      i_rx_valid = 1'b0;
      i_soft_reset = 1'b0;
      r_cyc = 0;
      repeat (5) tick();
      check("rst_ldlo_nwr", wr_addr_q.size() - w0, 0);

      // reset mid-dump
      prog_q = '{16'h1805, 16'h0000};
      load_prog();
      ready_mode = 2;
      tx_q.delete();
      ref_exec();
      send(8'h53);
      n = 0;
      while (tx_q.size() < 2 && n < 300) begin
         tick();
         n++;
      end
      check("rst_dump_reached", tx_q.size(), 2);
      i_soft_reset = 1'b1;
      @(posedge i_clock);
      @(negedge i_clock);
      check_zero("rst_dump");
      i_soft_reset = 1'b0;
      r_cyc = 0;
      repeat (20) tick();
      check("rst_dump_nbytes", tx_q.size(), 2);
      ready_mode = 0;

      // randomized programs and command mixes
      for (int it = 0; it < 8; it++) begin
         ready_mode = $urandom_range(0, 1);
         prog_q.delete();
         n = $urandom_range(1, 6);
         for (int k = 0; k < n; k++) begin
            case ($urandom_range(0, 3))
               0:       prog_q.push_back({OP_STO, 11'($urandom_range(0, 7))});
               1:       prog_q.push_back({OP_LD, 11'($urandom_range(0, 7))});
               2:       prog_q.push_back({OP_LDI, 11'($urandom_range(0, 2047))});
               default: prog_q.push_back({OP_ADDI, 11'($urandom_range(0, 2047))});
            endcase
         end
         prog_q.push_back(16'h0000);
         load_prog();
         repeat ($urandom_range(1, 4)) begin
            b = 8'($urandom_range(0, 255));
            if (b == 8'h4C || b == 8'h52 || b == 8'h53) b = 8'h41;
            send(b);
            check("rand_noise_busy", {31'd0, o_busy}, 32'd0);
            run_cmd(($urandom_range(0, 1) == 1) ? 8'h52 : 8'h53, 0, "rand");
         end
      end
      ready_mode = 0;

      // endless loop saturates the cycle counter; rx strobes during RUN are dropped
      prog_q = '{{OP_JMP, 11'd0}};
      load_prog();
      run_cmd(8'h52, 70000, "sat");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/bip_run_controller.md
Name: bip_run_controller

Overview:
- Sequences the BIP processor (PC, instruction decoder, accumulator datapath) from a byte-oriented host link.
- Loads program memory, resets the CPU, then runs it to HALT or single-steps it.
- Dumps PC, ACC and executed-cycle count back to the host.
- Sits between the serial receive/transmit blocks and the CPU core/program memory.

Parameters:
- PC_CANT_BITS, 11, PC/program address width.
- OPCODE_LENGTH, 5, opcode width.
- INSTR_WIDTH, 16, program word width (opcode + operand).
- DATA_WIDTH, 16, accumulator width.
- HALT_OPCODE, 5'b00000, opcode that stops execution.

Ports:
- i_clock  in  1  system clock.
- i_soft_reset  in  1  reset; synchronous, active-high.
- i_rx_data  in  8  received host byte.
- i_rx_valid  in  1  one-cycle strobe; i_rx_data valid.
- o_tx_data  out  8  byte to host.
- o_tx_valid  out  1  o_tx_data valid.
- i_tx_ready  in  1  transmitter accepts byte.
- o_prog_we  out  1  program memory write strobe.
- o_prog_addr  out  PC_CANT_BITS  program write address.
- o_prog_data  out  INSTR_WIDTH  program write word.
- o_cpu_enable  out  1  CPU advances one instruction per cycle while high.
- o_cpu_reset  out  1  one-cycle CPU soft reset pulse.
- i_opcode  in  OPCODE_LENGTH  opcode at current PC.
- i_pc  in  PC_CANT_BITS  current PC.
- i_acc  in  DATA_WIDTH  current accumulator.
- o_busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: at the first clock edge with i_soft_reset high, state becomes IDLE. All outputs, the byte counter, the address counter and the cycle counter are 0. This applies mid-operation, including during a tx transfer.
- States: IDLE, LD_COUNT, LD_HI, LD_LO, CPU_RST, RUN, STEP, DUMP.
- IDLE: on i_rx_valid, the command byte is decoded:
  - 0x4C 'L' -> LD_COUNT.
  - 0x52 'R' -> RUN.
  - 0x53 'S' -> STEP.
  - Any other byte is ignored.
- LD_COUNT: the next byte is N, the instruction count.
  - N=0 -> IDLE, no writes.
  - Otherwise store N, clear the address counter, go to LD_HI.
- LD_HI: the next byte is latched as the word MSB -> LD_LO.
- LD_LO: the next byte completes the word.
  - The cycle after the byte, o_prog_we=1 for exactly one cycle, with o_prog_addr = address counter and o_prog_data = {MSB, LSB}.
  - Address counter increments.
  - If N words have been written -> CPU_RST, else -> LD_HI.
- CPU_RST: o_cpu_reset=1 for one cycle, the cycle counter clears -> IDLE.
- RUN: o_cpu_enable = 1 whenever i_opcode != HALT_OPCODE. This is combinational from state and i_opcode, so the HALT instruction never executes.
  - The cycle counter increments on every enabled cycle and saturates at 16'hFFFF.
  - The first cycle with i_opcode == HALT_OPCODE -> DUMP, with enable low in that cycle.
- STEP: one cycle in the state.
  - o_cpu_enable=1 for that single cycle unless i_opcode == HALT_OPCODE. The counter increments if enabled.
  - Then -> DUMP.
- DUMP:
  - On entry, snapshot i_pc (zero-extended to 16 bits), i_acc (lowest 16 bits, zero-extended if DATA_WIDTH < 16) and the cycle counter.
  - Send 6 bytes, MSB first: PC_hi, PC_lo, ACC_hi, ACC_lo, CYC_hi, CYC_lo.
  - A byte transfers on a cycle with o_tx_valid && i_tx_ready. o_tx_data is held stable while o_tx_valid && !i_tx_ready.
  - o_tx_valid rises the cycle after DUMP entry. Back-to-back transfers are allowed when i_tx_ready stays high.
  - After the 6th transfer, o_tx_valid=0 -> IDLE.
- i_rx_valid strobes in CPU_RST, RUN, STEP and DUMP are dropped; no buffering.
- The CPU keeps its PC between commands: 'R' or 'S' after a halt re-dumps the same PC with no execution.
- o_cpu_enable and o_prog_we are never high in the same cycle.

Test Plan:
- Load and run: reset; send 0x4C, 0x03, words 0x0805, 0x1003, 0x0000; then 0x52.
  - Required: 3 writes at addr 0,1,2 with data 0x0805, 0x1003, 0x0000.
  - Required: one o_cpu_reset pulse; o_cpu_enable high for exactly 2 cycles.
  - Required: dump of PC=0x0002, ACC per model, CYC=0x0002.
- Step: after load, send 'S' three times.
  - Required: three 6-byte dumps with PC 0x0001, 0x0002, 0x0002 and CYC 1, 2, 2.
  - Required: no enable on the third step (HALT).
- Tx backpressure: hold i_tx_ready low 5 cycles per byte during dump.
  - Required: o_tx_data stable and o_tx_valid high throughout; 6 bytes delivered in order.
- Edge inputs: send N=0 and an unknown command 0x41.
  - Required: no writes, no CPU reset, o_busy low after 1 cycle.
  - Required: rx strobes during RUN are ignored.
- Reset mid-operation: assert i_soft_reset during LD_LO and, separately, mid-DUMP.
  - Required: all outputs 0 on the next edge; state IDLE; no partial write strobe.
- Saturation: a program that loops forever without HALT, released after 70000 cycles by the model changing i_opcode to HALT.
  - Required: CYC=0xFFFF.
